// File: rtl/mul_div_seq.sv
// EBOX multiply/divide step sequencer: radix-4 Booth multiply and non-restoring
// divide, driving EDP AD/ADB/AR/MQ/MQM controls each eboxClk from state plus feedback.
module mul_div_seq #(
  parameter int MUL_STEPS = 18,
  parameter int DIV_STEPS = 36,
  parameter int CNT_W     = 6
) (
  input  logic       eboxClk,
  input  logic       eboxReset,
  input  logic       start,
  input  logic       opDiv,
  input  logic [1:0] EDP_MQ34_35,
  input  logic       EDP_ADcarryM2,
  output logic [6:0] adFunc,
  output logic [1:0] adbSel,
  output logic [2:0] arlSel,
  output logic [2:0] arrSel,
  output logic       arLoad,
  output logic [1:0] mqSel,
  output logic [1:0] mqmSel,
  output logic       mqmEn,
  output logic       busy,
  output logic       done,
  output logic       divOvf
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] MUL_STEP = 3'd1;
  localparam logic [2:0] DIV_CHK  = 3'd2;
  localparam logic [2:0] DIV_STEP = 3'd3;
  localparam logic [2:0] DIV_FIX  = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam logic [6:0] AD_A     = 7'o37;
  localparam logic [6:0] AD_APLUS = 7'o06;
  localparam logic [6:0] AD_AMIN  = 7'o51;
  localparam logic [1:0] ADB_BR   = 2'b10;
  localparam logic [1:0] ADB_BR2  = 2'b01;

  // A zero step count would underflow the counter, so it runs as a single step.
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'((MUL_STEPS == 0) ? 1 : MUL_STEPS);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'((DIV_STEPS == 0) ? 1 : DIV_STEPS);

  logic [2:0]       state;
  logic [CNT_W-1:0] counter;
  logic             boothCry;
  logic             qPrev;
  logic             lastStep;
  logic [2:0]       boothCode;

  assign lastStep  = (counter <= CNT_W'(1));
  assign boothCode = {EDP_MQ34_35[1], EDP_MQ34_35[0], boothCry};

  always_ff @(posedge eboxClk) begin
    if (eboxReset) begin
      state    <= IDLE;
      counter  <= '0;
      boothCry <= 1'b0;
      qPrev    <= 1'b0;
      divOvf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            boothCry <= 1'b0;
            qPrev    <= 1'b0;
            divOvf   <= 1'b0;
            counter  <= opDiv ? DIV_CNT : MUL_CNT;
            state    <= opDiv ? DIV_CHK : MUL_STEP;
          end
        end
        MUL_STEP: begin
          boothCry <= EDP_MQ34_35[1];
          if (counter != '0) counter <= counter - CNT_W'(1);
          if (lastStep) state <= DONE;
        end
        DIV_CHK: begin
          if (EDP_ADcarryM2) begin
            divOvf <= 1'b1;
            state  <= DONE;
          end else begin
            qPrev <= 1'b0;
            state <= DIV_STEP;
          end
        end
        DIV_STEP: begin
          qPrev <= EDP_ADcarryM2;
          if (counter != '0) counter <= counter - CNT_W'(1);
          // A negative final remainder (last quotient bit 0) needs one add-back cycle.
          if (lastStep) state <= EDP_ADcarryM2 ? DONE : DIV_FIX;
        end
        DIV_FIX: state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    adFunc = AD_A;
    adbSel = ADB_BR;
    arlSel = 3'b000;
    arrSel = 3'b000;
    arLoad = 1'b0;
    mqSel  = 2'b11;
    mqmSel = 2'b00;
    mqmEn  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      MUL_STEP: begin
        busy = 1'b1;
        case (boothCode)
          3'b001, 3'b010: adFunc = AD_APLUS;
          3'b011: begin
            adFunc = AD_APLUS;
            adbSel = ADB_BR2;
          end
          3'b100: begin
            adFunc = AD_AMIN;
            adbSel = ADB_BR2;
          end
          3'b101, 3'b110: adFunc = AD_AMIN;
          default: adFunc = AD_A;
        endcase
        arLoad = 1'b1;
        arlSel = 3'b111;
        arrSel = 3'b111;
        mqSel  = 2'b00;
        mqmSel = 2'b00;
        mqmEn  = 1'b1;
      end
      DIV_CHK: begin
        busy   = 1'b1;
        adFunc = AD_AMIN;
      end
      DIV_STEP: begin
        busy   = 1'b1;
        adFunc = qPrev ? AD_AMIN : AD_APLUS;
        arLoad = 1'b1;
        arlSel = 3'b101;
        arrSel = 3'b101;
        mqSel  = 2'b01;
        mqmSel = 2'b01;
        mqmEn  = 1'b1;
      end
      DIV_FIX: begin
        busy   = 1'b1;
        adFunc = AD_APLUS;
        arLoad = 1'b1;
        arlSel = 3'b010;
        arrSel = 3'b010;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed bench for mul_div_seq: Booth recode, divide steps, overflow, reset and
// start-while-busy behaviour against hand-computed control words.
module tb_mul_div_seq;

  logic       eboxClk = 1'b0;
  logic       eboxReset;
  logic       start;
  logic       opDiv;
  logic [1:0] mq;
  logic       carry;
  logic [6:0] adFunc;
  logic [1:0] adbSel;
  logic [2:0] arlSel;
  logic [2:0] arrSel;
  logic       arLoad;
  logic [1:0] mqSel;
  logic [1:0] mqmSel;
  logic       mqmEn;
  logic       busy;
  logic       done;
  logic       divOvf;

  int checkCount = 0;
  int passCount  = 0;
  int n;
  int pulses;

  mul_div_seq dut (
    .eboxClk(eboxClk), .eboxReset(eboxReset), .start(start), .opDiv(opDiv),
    .EDP_MQ34_35(mq), .EDP_ADcarryM2(carry), .adFunc(adFunc), .adbSel(adbSel),
    .arlSel(arlSel), .arrSel(arrSel), .arLoad(arLoad), .mqSel(mqSel),
    .mqmSel(mqmSel), .mqmEn(mqmEn), .busy(busy), .done(done), .divOvf(divOvf)
  );

  always #5 eboxClk = ~eboxClk;

  function automatic logic [20:0] ctl(input logic [6:0] ad, input logic [1:0] adb,
                                      input logic [2:0] arl, input logic [2:0] arr,
                                      input logic ld, input logic [1:0] mqs,
                                      input logic [1:0] mqm, input logic en);
    return {ad, adb, arl, arr, ld, mqs, mqm, en};
  endfunction

  function automatic logic [20:0] ctlNow();
    return {adFunc, adbSel, arlSel, arrSel, arLoad, mqSel, mqmSel, mqmEn};
  endfunction

  task automatic applyStimulus(input logic s, input logic d, input logic [1:0] m,
                               input logic c);
    start = s;
    opDiv = d;
    mq    = m;
    carry = c;
    #1;
  endtask

  task automatic cycle();
    @(posedge eboxClk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Returns the cycle number (relative to start) on which done is seen; 100 = timeout.
  task automatic waitDone(input int from, output int cyc);
    cyc = from;
    while (done !== 1'b1 && cyc < 100) begin
      cycle();
      cyc++;
    end
  endtask

  task automatic startOp(input logic d, input logic [1:0] m, input logic c);
    applyStimulus(1'b1, d, m, c);
    cycle();
    applyStimulus(1'b0, d, m, c);
  endtask

  initial begin
    logic [20:0] idleCtl;
    logic [20:0] mulA;
    idleCtl = ctl(7'o37, 2'b10, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00, 1'b0);
    mulA    = ctl(7'o37, 2'b10, 3'b111, 3'b111, 1'b1, 2'b00, 2'b00, 1'b1);

    eboxReset = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    cycle();
    cycle();
    eboxReset = 1'b0;
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_divOvf", divOvf, 0);
    checkOutput("reset_ctl", ctlNow(), idleCtl);

    $display("[TB] multiply, MQ held 11");
    startOp(1'b0, 2'b11, 1'b0);
    checkOutput("mul11_busy", busy, 1);
    checkOutput("mul11_step1", ctlNow(),
                ctl(7'o51, 2'b10, 3'b111, 3'b111, 1'b1, 2'b00, 2'b00, 1'b1));
    for (int k = 2; k <= 18; k++) begin
      cycle();
      checkOutput($sformatf("mul11_step%0d", k), ctlNow(), mulA);
      checkOutput($sformatf("mul11_nodone%0d", k), done, 0);
    end
    cycle();
    checkOutput("mul11_done19", done, 1);
    cycle();
    checkOutput("mul11_done_cleared", done, 0);
    checkOutput("mul11_idle_ctl", ctlNow(), idleCtl);

    $display("[TB] multiply, Booth carry tracking");
    startOp(1'b0, 2'b01, 1'b0);
    checkOutput("booth_010", ctlNow(),
                ctl(7'o06, 2'b10, 3'b111, 3'b111, 1'b1, 2'b00, 2'b00, 1'b1));
    cycle();
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0);
    checkOutput("booth_100", ctlNow(),
                ctl(7'o51, 2'b01, 3'b111, 3'b111, 1'b1, 2'b00, 2'b00, 1'b1));
    cycle();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("booth_001", ctlNow(),
                ctl(7'o06, 2'b10, 3'b111, 3'b111, 1'b1, 2'b00, 2'b00, 1'b1));
    cycle();
    checkOutput("booth_000", ctlNow(), mulA);
    waitDone(4, n);
    checkOutput("booth_done_cycle", n, 19);

    $display("[TB] divide overflow");
    cycle();
    startOp(1'b1, 2'b00, 1'b1);
    checkOutput("ovf_chk_ctl", ctlNow(),
                ctl(7'o51, 2'b10, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00, 1'b0));
    cycle();
    checkOutput("ovf_done2", done, 1);
    checkOutput("ovf_flag", divOvf, 1);
    checkOutput("ovf_arLoad", arLoad, 0);
    cycle();
    checkOutput("ovf_sticky", divOvf, 1);
    checkOutput("ovf_idle_ctl", ctlNow(), idleCtl);

    $display("[TB] divide with remainder correction");
    startOp(1'b1, 2'b00, 1'b0);
    checkOutput("div_ovf_cleared", divOvf, 0);
    for (int k = 1; k <= 36; k++) begin
      cycle();
      applyStimulus(1'b0, 1'b1, 2'b00, (k % 2) == 1);
      checkOutput($sformatf("div_step%0d", k), ctlNow(),
                  ctl(((k % 2) == 1) ? 7'o06 : 7'o51, 2'b10, 3'b101, 3'b101,
                      1'b1, 2'b01, 2'b01, 1'b1));
    end
    cycle();
    checkOutput("div_fix_ctl", ctlNow(),
                ctl(7'o06, 2'b10, 3'b010, 3'b010, 1'b1, 2'b11, 2'b00, 1'b0));
    checkOutput("div_fix_nodone", done, 0);
    cycle();
    checkOutput("div_done39", done, 1);
    checkOutput("div_no_ovf", divOvf, 0);

    $display("[TB] divide without remainder correction");
    cycle();
    startOp(1'b1, 2'b00, 1'b0);
    cycle();
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b1);
    waitDone(2, n);
    checkOutput("div_nofix_done_cycle", n, 38);

    $display("[TB] reset during multiply");
    cycle();
    startOp(1'b0, 2'b00, 1'b0);
    for (int k = 2; k <= 5; k++) cycle();
    eboxReset = 1'b1;
    cycle();
    eboxReset = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_arLoad", arLoad, 0);
    checkOutput("rst_mqSel", mqSel, 2'b11);
    checkOutput("rst_done", done, 0);
    startOp(1'b0, 2'b00, 1'b0);
    waitDone(1, n);
    checkOutput("rst_rerun_done_cycle", n, 19);

    $display("[TB] start while busy");
    cycle();
    startOp(1'b0, 2'b00, 1'b0);
    for (int k = 2; k <= 4; k++) cycle();
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
    cycle();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("busy_restart_ctl", ctlNow(), mulA);
    waitDone(5, n);
    checkOutput("busy_done_cycle", n, 19);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (done === 1'b1) pulses++;
    end
    checkOutput("busy_single_done", pulses, 0);
    checkOutput("busy_final_idle", busy, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
